// File: rtl/key_scan_pkg.sv
// ---------------------------------------------------------------------------
// key_scan_pkg -- shared constants and helpers for the 4x4 key matrix scanner.
//   ROWS / COLS : matrix geometry
//   NKEYS       : number of keys (ROWS*COLS)
//   KEY_W       : width of a key index (row*COLS + col)
//   ROW_W       : width of the row index
//   row_drive() : one-hot-low row drive pattern for a given row index
// ---------------------------------------------------------------------------
package key_scan_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NKEYS = ROWS * COLS;
    localparam int KEY_W = 4;
    localparam int ROW_W = 2;

    // Row r is driven low, all other rows high (r=0 -> 4'b1110).
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
        logic [ROWS-1:0] one_hot;
        one_hot = {{(ROWS-1){1'b0}}, 1'b1} << row;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// ---------------------------------------------------------------------------
// key_scan_if -- key event stream (valid/ready handshake).
//   key_valid : event available in the output slot
//   key_ready : consumer accepts the event (ignored while key_valid=0)
//   key_code  : key index = row*4 + col
//   key_rel   : 1 = release event, 0 = press event
// Modports: master (the scanner), slave (the consumer).
// ---------------------------------------------------------------------------
interface key_scan_if;
    import key_scan_pkg::*;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_code;
    logic             key_rel;

    modport master (output key_valid, output key_code, output key_rel, input key_ready);
    modport slave  (input key_valid, input key_code, input key_rel, output key_ready);

endinterface

// File: rtl/key_scan_arb.sv
// ---------------------------------------------------------------------------
// key_scan_arb -- lowest-index priority picker over N request bits.
//   req   : request vector (bit 0 has highest priority)
//   found : at least one request is set
//   idx   : index of the lowest set request (0 when none)
// ---------------------------------------------------------------------------
module key_scan_arb #(
    parameter int N = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/key_scan.sv
// ---------------------------------------------------------------------------
// key_scan -- 4x4 key matrix scanner with per-key debounce and an event slot.
//   clk      : system clock
//   rst      : synchronous, active-low reset
//   key_row  : active-low row drive (registered)
//   key_col  : active-low column sense, already synchronised (0 = closed)
//   key_if   : event stream (key_scan_if.master): valid/ready/code/rel
//   key_held : debounced stable state per key (1 = held)
//   key_ovf  : one-cycle pulse when a new event merges into a pending one
// Parameters: SCAN_DIV (clk cycles per row step, >= 2),
//             DEBOUNCE_CNT (differing samples to flip a key, >= 1).
// Build option: define KEY_SCAN_RELEASE_EN to also report release events;
// otherwise only presses are reported and key_rel is tied low.
// ---------------------------------------------------------------------------
module key_scan
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  key_row,
    input  logic [COLS-1:0]  key_col,
    key_scan_if.master       key_if,
    output logic [NKEYS-1:0] key_held,
    output logic             key_ovf
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

`ifdef KEY_SCAN_RELEASE_EN
    localparam int NREQ = 2 * NKEYS;
`else
    localparam int NREQ = NKEYS;
`endif
    localparam int IW = $clog2(NREQ);

    logic [PW-1:0]    pre;
    logic [ROW_W-1:0] row;
    logic             tick;

    logic [CW-1:0]    cnt     [NKEYS];
    logic [CW-1:0]    cnt_nxt [NKEYS];
    logic [NKEYS-1:0] held_nxt;

    logic [NKEYS-1:0] press_pend, press_set, press_clr, press_nxt;

    logic             slot_valid;
    logic [KEY_W-1:0] slot_code;

    logic [NREQ-1:0]  req;
    logic             found;
    logic [IW-1:0]    pick_idx;
    logic [KEY_W-1:0] pick_code;
    logic             pick_rel;
    logic             load;
    logic             take;
    logic             ovf_nxt;

    assign tick = (pre == PW'(SCAN_DIV - 1));

    // Debounce: each key sees one sample per full scan, on the tick of its row.
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        held_nxt = key_held;
        cnt_nxt  = cnt;
        if (tick) begin
            for (int c = 0; c < COLS; c++) begin
                if (!key_col[c] == key_held[{row, 2'(c)}]) begin
                    cnt_nxt[{row, 2'(c)}] = '0;
                end else if (cnt[{row, 2'(c)}] == CW'(DEBOUNCE_CNT - 1)) begin
                    held_nxt[{row, 2'(c)}] = ~key_held[{row, 2'(c)}];
                    cnt_nxt[{row, 2'(c)}]  = '0;
                end else begin
                    cnt_nxt[{row, 2'(c)}] = cnt[{row, 2'(c)}] + CW'(1);
                end
            end
        end
    end

    assign press_set = held_nxt & ~key_held;

    // The slot accepts a new event when empty or when its current one leaves.
    assign load = !slot_valid || key_if.key_ready;
    assign take = load && found;

    always_comb begin
        press_clr = '0;
        if (take && !pick_rel) press_clr[pick_code] = 1'b1;
    end

    // Clear before set: a bit set and consumed on the same edge stays set.
    assign press_nxt = (press_pend & ~press_clr) | press_set;

`ifdef KEY_SCAN_RELEASE_EN
    logic [NKEYS-1:0] rel_pend, rel_set, rel_clr, rel_nxt;
    logic             slot_rel;

    assign rel_set = key_held & ~held_nxt;

    always_comb begin
        rel_clr = '0;
        if (take && pick_rel) rel_clr[pick_code] = 1'b1;
    end

    assign rel_nxt = (rel_pend & ~rel_clr) | rel_set;

    // Interleave press/release per key so that, for one key index, the press
    // (even slot) wins over the release (odd slot).
    always_comb begin
        req = '0;
        for (int k = 0; k < NKEYS; k++) begin
            req[2*k]   = press_pend[k];
            req[2*k+1] = rel_pend[k];
        end
    end

    assign pick_code = pick_idx[IW-1:1];
    assign pick_rel  = pick_idx[0];

    assign ovf_nxt = |(press_set & press_pend & ~press_clr)
                   | |(rel_set & rel_pend & ~rel_clr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rel_pend <= '0;
            slot_rel <= 1'b0;
        end else begin
            rel_pend <= rel_nxt;
            if (take) slot_rel <= pick_rel;
        end
    end

    assign key_if.key_rel = slot_rel;
`else
    assign req       = press_pend;
    assign pick_code = pick_idx;
    assign pick_rel  = 1'b0;
    assign ovf_nxt   = |(press_set & press_pend & ~press_clr);

    assign key_if.key_rel = 1'b0;
`endif

    key_scan_arb #(.N(NREQ)) u_arb (
        .req   (req),
        .found (found),
        .idx   (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre        <= '0;
            row        <= '0;
            key_row    <= row_drive('0);
            key_held   <= '0;
            press_pend <= '0;
            slot_valid <= 1'b0;
            slot_code  <= '0;
            key_ovf    <= 1'b0;
            // NOTE: the debounce counters are individual flops, not a RAM,
            // so clearing them all on reset is cheap and required.
            for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                row     <= row + ROW_W'(1);
                key_row <= row_drive(row + ROW_W'(1));
            end
            cnt        <= cnt_nxt;
            key_held   <= held_nxt;
            press_pend <= press_nxt;
            key_ovf    <= ovf_nxt;
            if (load) slot_valid <= found;
            if (take) slot_code  <= pick_code;
        end
    end

    assign key_if.key_valid = slot_valid;
    assign key_if.key_code  = slot_code;

endmodule

// File: tb/tb_key_scan.sv
// ---------------------------------------------------------------------------
// tb_key_scan -- self-checking bench for key_scan (SCAN_DIV=4, DEBOUNCE_CNT=2).
// A behavioural model tracks the scan position, per-key debounce, the pending
// press/release sets and the output slot; DUT outputs are compared with it
// after every clock edge. Directed phases cover reset, press, release, bounce,
// backpressure, overrun and reset with a stalled event, then random traffic.
// Honours KEY_SCAN_RELEASE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_key_scan;
    import key_scan_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [15:0] key_held;
    logic        key_ovf;

    logic [15:0] closed = '0;   // physical switch state, 1 = closed
    logic        ready  = 1'b1;

    key_scan_if kif ();
    assign kif.key_ready = ready;

    key_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_if   (kif),
        .key_held (key_held),
        .key_ovf  (key_ovf)
    );

    always #5 clk = ~clk;

    // Passive matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (key_row[r] === 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (closed[r*4+c]) key_col[c] = 1'b0;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ovf_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ model
    int          m_pre;
    int          m_row;
    int          m_cnt [16];
    bit [15:0]   m_held, m_pp, m_rp;
    bit          m_valid, m_rel, m_ovf;
    int          m_code;

    task automatic model_edge();
        bit [15:0] nh, pset, rset, pclr, rclr;
        bit        got;
        if (!rst) begin
            m_pre = 0; m_row = 0; m_held = '0; m_pp = '0; m_rp = '0;
            m_valid = 0; m_code = 0; m_rel = 0; m_ovf = 0;
            for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        end else begin
            nh = m_held;
            if (m_pre == SCAN_DIV - 1) begin
                for (int c = 0; c < 4; c++) begin
                    int k;
                    k = m_row * 4 + c;
                    if (closed[k] == m_held[k]) m_cnt[k] = 0;
                    else begin
                        m_cnt[k]++;
                        if (m_cnt[k] == DEB) begin
                            nh[k] = !nh[k];
                            m_cnt[k] = 0;
                        end
                    end
                end
                m_row = (m_row + 1) % 4;
            end
            m_pre = (m_pre + 1) % SCAN_DIV;
            pset = nh & ~m_held;
`ifdef KEY_SCAN_RELEASE_EN
            rset = m_held & ~nh;
`else
            rset = '0;
`endif
            pclr = '0; rclr = '0;
            if (!m_valid || ready) begin
                got = 0;
                for (int k = 0; k < 16 && !got; k++) begin
                    if (m_pp[k]) begin
                        got = 1; m_code = k; m_rel = 0; pclr[k] = 1;
                    end else if (m_rp[k]) begin
                        got = 1; m_code = k; m_rel = 1; rclr[k] = 1;
                    end
                end
                m_valid = got;
            end
            m_ovf  = (|(pset & m_pp & ~pclr)) || (|(rset & m_rp & ~rclr));
            m_pp   = (m_pp & ~pclr) | pset;
            m_rp   = (m_rp & ~rclr) | rset;
            m_held = nh;
        end
    endtask

    // --------------------------------------------------- delivered events
    typedef struct {
        int code;
        bit rel;
        int cyc;
    } dlv_t;
    dlv_t dq[$];

    function automatic int count_ev(input int code, input bit rel, input int from);
        int n = 0;
        for (int i = from; i < dq.size(); i++)
            if (dq[i].code == code && dq[i].rel == rel) n++;
        return n;
    endfunction

    task automatic step();
        logic [3:0] exp_row;
        if (rst && kif.key_valid === 1'b1 && ready)
            dq.push_back('{code: int'(kif.key_code), rel: kif.key_rel, cyc: cyc});
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        exp_row = 4'hF ^ (4'h1 << m_row);
        check("row", key_row, exp_row);
        check("held", key_held, m_held);
        check("valid", kif.key_valid, m_valid);
        if (m_valid) begin
            check("code", kif.key_code, m_code);
            check("rel", kif.key_rel, m_rel);
        end
        check("ovf", key_ovf, m_ovf);
        if (key_ovf === 1'b1) ovf_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // ------------------------------------------------------- stimulus
    initial begin
        int d0, ovf0, bounce_bad, bound;
        bit rel_en;
`ifdef KEY_SCAN_RELEASE_EN
        rel_en = 1;
`else
        rel_en = 0;
`endif

        // Reset state and first row step.
        repeat (3) step();
        check("rst_row", key_row, 4'b1110);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", key_ovf, 0);
        rst = 1'b1;
        run(3);
        check("row_hold", key_row, 4'b1110);
        step();
        check("row_step", key_row, 4'b1101);

        // Press key 6 (row 1, col 2).
        d0 = dq.size();
        closed[6] = 1'b1;
        bound = 0;
        while (key_held[6] !== 1'b1 && bound < 64) begin step(); bound++; end
        check("press_held", key_held[6], 1);
        step();
        check("press_valid", kif.key_valid, 1);
        check("press_code", kif.key_code, 6);
        check("press_rel", kif.key_rel, 0);
        run(4);
        check("press_count", count_ev(6, 0, d0), 1);

        // Release key 6.
        d0 = dq.size();
        closed[6] = 1'b0;
        run(64);
        check("release_held", key_held[6], 0);
        check("release_events", dq.size() - d0, rel_en ? 1 : 0);
        check("release_count", count_ev(6, 1, d0), rel_en ? 1 : 0);

        // Bounce: flip key 6 once per full scan, so samples alternate.
        run(8);
        d0 = dq.size();
        bounce_bad = 0;
        for (int i = 0; i < 8; i++) begin
            closed[6] = !closed[6];
            repeat (16) begin
                step();
                if (key_held[6] !== 1'b0) bounce_bad++;
            end
        end
        closed[6] = 1'b0;
        run(40);
        check("bounce_held", bounce_bad, 0);
        check("bounce_events", dq.size() - d0, 0);

        // Backpressure: keys 2 and 9 pressed together, slot stalled.
        bound = 0;
        while (m_row != 0 && bound < 20) begin step(); bound++; end
        check("bp_align", m_row, 0);
        ready = 1'b0;
        closed[2] = 1'b1;
        closed[9] = 1'b1;
        d0 = dq.size();
        run(48);
        check("bp_held", key_held & 16'h0204, 16'h0204);
        check("bp_valid", kif.key_valid, 1);
        check("bp_code", kif.key_code, 2);
        run(10);
        check("bp_code_stable", kif.key_code, 2);
        ready = 1'b1;
        run(4);
        check("bp_events", dq.size() - d0, 2);
        if (dq.size() - d0 >= 2) begin
            check("bp_first", dq[d0].code, 2);
            check("bp_second", dq[d0+1].code, 9);
            check("bp_b2b", dq[d0+1].cyc - dq[d0].cyc, 1);
        end
        closed = '0;
        run(64);

        // Overrun: key 0 blocks the slot while key 5 is pressed twice.
        ready = 1'b0;
        d0 = dq.size();
        ovf0 = ovf_seen;
        closed[0] = 1'b1;
        run(48);
        closed[5] = 1'b1;
        run(48);
        closed[5] = 1'b0;
        run(48);
        closed[5] = 1'b1;
        run(48);
        check("ovf_pulses", ovf_seen - ovf0, 1);
        ready = 1'b1;
        run(8);
        check("ovf_press5", count_ev(5, 0, d0), 1);
        check("ovf_rel5", count_ev(5, 1, d0), rel_en ? 1 : 0);
        closed = '0;
        run(64);

        // Random traffic with random backpressure.
        for (int it = 0; it < 40; it++) begin
            int len;
            case ($urandom_range(0, 3))
                0: closed = 16'($urandom);
                1: closed = '0;
                default: closed[$urandom_range(0, 15)] = !closed[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(8, 80);
            repeat (len) begin
                ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        ready = 1'b1;
        closed = '0;
        run(80);

        // Reset while an event sits stalled in the slot.
        ready = 1'b0;
        closed[3] = 1'b1;
        bound = 0;
        while (kif.key_valid !== 1'b1 && bound < 64) begin step(); bound++; end
        check("pre_rst_valid", kif.key_valid, 1);
        run(5);
        rst = 1'b0;
        run(2);
        check("mid_rst_valid", kif.key_valid, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_row", key_row, 4'b1110);
        closed = '0;
        ready = 1'b1;
        rst = 1'b1;
        d0 = dq.size();
        run(40);
        check("no_residual", dq.size() - d0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 5000, meaning clk cycles per row step (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 4, meaning consecutive differing samples needed to change a key's stable state (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port key_row, output, 4 bits, active-low row drive of the 4x4 key matrix.
REQ-006 The block SHALL have port key_col, input, 4 bits, active-low column sense (0 = key closed), already synchronised externally.
REQ-007 The block SHALL have port key_valid, output, 1 bit, event available.
REQ-008 The block SHALL have port key_ready, input, 1 bit, consumer accepts the event.
REQ-009 The block SHALL have port key_code, output, 4 bits, event key index = row*4 + col.
REQ-010 The block SHALL have port key_rel, output, 1 bit, where 1 = release event and 0 = press event.
REQ-011 The block SHALL have port key_held, output, 16 bits, debounced stable state per key (1 = held).
REQ-012 The block SHALL have port key_ovf, output, 1 bit, one-cycle pulse when a new event merges into an already-pending one.

Function
REQ-013 A prescaler SHALL count 0..SCAN_DIV-1 and wrap, asserting an internal tick on the cycle it equals SCAN_DIV-1.
REQ-014 Row index r SHALL drive key_row with bit r low and all other bits high (r=0 -> 4'b1110).
REQ-015 On tick, the block SHALL sample ~key_col as the raw state of keys r*4..r*4+3 and then advance r, wrapping from 3 to 0.
REQ-016 Per key debounce on each sample of that key: if raw equals stable, the counter SHALL clear; otherwise the counter SHALL increment, and when it reaches DEBOUNCE_CNT the stable bit SHALL toggle and the counter SHALL clear.
REQ-017 A stable 0->1 transition SHALL set that key's bit in a 16-bit press-pending mask on the same edge.
REQ-018 If the key's pending bit is already set at that edge and the bit is not being cleared in the same cycle, key_ovf SHALL pulse for one cycle.
REQ-019 The output slot SHALL be a register; key_valid, key_code and key_rel SHALL stay constant while key_valid=1 and key_ready=0.
REQ-020 When the slot is empty, or key_valid&&key_ready in this cycle, the block SHALL load the lowest-index pending event and clear its pending bit on the same edge, giving back-to-back throughput.
REQ-021 Arbitration SHALL pick the lowest key index first and, for the same index, press before release.
REQ-022 A pending bit set and consumed on the same edge SHALL remain set.
REQ-023 key_ready SHALL be ignored while key_valid=0.

Reset
REQ-024 While rst=0 at a clk edge, the block SHALL set: prescaler=0, r=0, key_row=4'b1110, debounce counters=0, key_held=0, pending masks=0, key_valid=0, key_code=0, key_rel=0, key_ovf=0.
REQ-025 Reset asserted mid-scan or with an event in the slot SHALL discard all state with no residual event.

Configuration
REQ-026 With macro KEY_SCAN_RELEASE_EN defined, stable 1->0 transitions SHALL set a separate release-pending mask handled as in REQ-017..022, with key_rel=1.
REQ-027 Without KEY_SCAN_RELEASE_EN, release events SHALL NOT be generated, key_rel SHALL be tied 0, and the release mask SHALL NOT be built.

Structure
REQ-028 A shared package SHALL hold the row count (4), column count (4), key-index width (4) and the row-drive one-hot-low encoding function.
REQ-029 One sub-module, key_scan_arb, SHALL implement the 16/32-entry lowest-index priority picker; all other logic SHALL reside in key_scan.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-030 Reset check: rst=0 for 3 cycles -> key_row=4'b1110, key_valid=0, key_held=0; after release, key_row=4'b1101 four cycles later.
REQ-031 Press test: hold key 6 (row 1, col 2) closed -> key_held[6]=1 after 2 samples of row 1, then key_valid=1, key_code=6, key_rel=0.
REQ-032 Bounce test: toggle key 6 every sample -> key_held[6] never changes and no event is produced.
REQ-033 Backpressure test: press keys 9 and 2 simultaneously with key_ready=0 -> key_code=2 held stable; after key_ready=1, codes 2 then 9 appear on consecutive cycles.
REQ-034 Overrun test: press, release and re-press key 5 while the slot is stalled -> key_ovf pulses once and exactly one press event for 5 is delivered.
REQ-035 Release test with KEY_SCAN_RELEASE_EN: release key 6 -> event with key_code=6 and key_rel=1; without the macro, no event is produced.
